// File: rtl/matvec_param_stream.sv
// Streaming KxK signed matrix-vector multiplier with matrix reuse.
// A job is either K*K matrix words followed by K vector words, or K vector words alone when the
// previously loaded matrix is reused. Results come out one row at a time, with output_last on the
// final row. A single sequential MAC produces one product per cycle.
// Optional feature: define MATVEC_SAT_EN for a saturating, sticky-clamped accumulator. The default
// build wraps modulo 2^OUT_W.
module matvec_param_stream #(
    parameter int unsigned K     = 3,
    parameter int unsigned IN_W  = 14,
    parameter int unsigned OUT_W = 28
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic signed [IN_W-1:0]  input_data,
    input  logic                    input_new_matrix,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic signed [OUT_W-1:0] output_data,
    output logic                    output_last
);

    localparam int unsigned IDX_W = $clog2(K * K);
    localparam int unsigned COL_W = $clog2(K);
    localparam logic [IDX_W-1:0] LAST_M = IDX_W'(K * K - 1);
    localparam logic [IDX_W-1:0] LAST_X = IDX_W'(K - 1);
    localparam logic [COL_W-1:0] LAST_C = COL_W'(K - 1);

    typedef enum logic [2:0] {S_FIRST, S_LOAD_M, S_LOAD_X, S_MAC, S_OUT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_in_en;
    logic                    r_mloaded;
    logic signed [IN_W-1:0]  r_mat [K*K];
    logic signed [IN_W-1:0]  r_vec [K];
    logic [IDX_W-1:0]        r_ld_idx;
    logic [IDX_W-1:0]        r_midx;
    logic [COL_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic signed [OUT_W-1:0] r_acc;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_last;

    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_first_is_m;
    logic                      w_wr_mat;
    logic signed [2*IN_W-1:0]  w_prod;
    logic signed [OUT_W-1:0]   w_prod_ext;
    logic signed [OUT_W-1:0]   w_acc_nxt;
`ifdef MATVEC_SAT_EN
    localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    logic                      r_sat;
    logic                      w_sat_nxt;
    logic [OUT_W:0]            w_sum;
`endif

    assign output_valid = r_out_valid;
    assign output_data  = r_out_data;
    assign output_last  = r_out_last;

    // Handshake decode and datapath arithmetic.
    always_comb begin
        input_ready  = r_in_en &&
                       (r_state == S_FIRST || r_state == S_LOAD_M || r_state == S_LOAD_X);
        w_in_fire    = input_valid && input_ready;
        w_out_fire   = r_out_valid && output_ready;
        w_first_is_m = input_new_matrix || !r_mloaded;
        // r_ld_idx is always 0 in S_FIRST, so it addresses the first word as well.
        w_wr_mat     = (r_state == S_LOAD_M) || (r_state == S_FIRST && w_first_is_m);
        w_prod       = r_mat[r_midx] * r_vec[r_col];
        w_prod_ext   = OUT_W'(w_prod);
`ifdef MATVEC_SAT_EN
        w_sum     = {r_acc[OUT_W-1], r_acc} + {w_prod_ext[OUT_W-1], w_prod_ext};
        w_acc_nxt = w_sum[OUT_W-1:0];
        w_sat_nxt = r_sat;
        if (r_sat) begin
            // Once clamped the row stays on its rail.
            w_acc_nxt = r_acc;
        end else if (w_sum[OUT_W] != w_sum[OUT_W-1]) begin
            w_acc_nxt = w_sum[OUT_W] ? ACC_MIN : ACC_MAX;
            w_sat_nxt = 1'b1;
        end
`else
        w_acc_nxt = r_acc + w_prod_ext;
`endif
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FIRST:  if (w_in_fire) w_state_nxt = w_first_is_m ? S_LOAD_M : S_LOAD_X;
            S_LOAD_M: if (w_in_fire && r_ld_idx == LAST_M) w_state_nxt = S_LOAD_X;
            S_LOAD_X: if (w_in_fire && r_ld_idx == LAST_X) w_state_nxt = S_MAC;
            S_MAC:    if (r_col == LAST_C) w_state_nxt = S_OUT;
            S_OUT:    if (w_out_fire) w_state_nxt = (r_row == LAST_C) ? S_FIRST : S_MAC;
            default:  w_state_nxt = S_FIRST;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, accumulator, flags and the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_en     <= 1'b0;
            r_mloaded   <= 1'b0;
            r_ld_idx    <= '0;
            r_midx      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
`ifdef MATVEC_SAT_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            r_in_en <= 1'b1;
            case (r_state)
                S_FIRST: begin
                    if (w_in_fire) begin
                        r_ld_idx <= IDX_W'(1);
                        // The old matrix is invalid while a new one streams in.
                        if (w_first_is_m) r_mloaded <= 1'b0;
                    end
                end
                S_LOAD_M: begin
                    if (w_in_fire) begin
                        if (r_ld_idx == LAST_M) begin
                            r_ld_idx  <= '0;
                            r_mloaded <= 1'b1;
                        end else begin
                            r_ld_idx <= r_ld_idx + IDX_W'(1);
                        end
                    end
                end
                S_LOAD_X: begin
                    if (w_in_fire) begin
                        if (r_ld_idx == LAST_X) begin
                            r_ld_idx <= '0;
                            r_midx   <= '0;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_acc    <= '0;
`ifdef MATVEC_SAT_EN
                            r_sat    <= 1'b0;
`endif
                        end else begin
                            r_ld_idx <= r_ld_idx + IDX_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_acc  <= w_acc_nxt;
`ifdef MATVEC_SAT_EN
                    r_sat  <= w_sat_nxt;
`endif
                    // Row-major storage: the matrix index simply walks across rows.
                    r_midx <= r_midx + IDX_W'(1);
                    if (r_col == LAST_C) begin
                        r_col       <= '0;
                        r_out_data  <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_row == LAST_C);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_row != LAST_C) begin
                            r_row <= r_row + COL_W'(1);
                            r_acc <= '0;
`ifdef MATVEC_SAT_EN
                            r_sat <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Matrix and vector storage; validity is tracked by r_mloaded, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            if (w_wr_mat) begin
                r_mat[r_ld_idx] <= input_data;
            end else begin
                r_vec[r_ld_idx[COL_W-1:0]] <= input_data;
            end
        end
    end

endmodule

// File: tb/tb_matvec_param_stream.sv
// Scoreboard bench for matvec_param_stream (K=3, IN_W=14, OUT_W=28).
module tb_matvec_param_stream;

    localparam int K     = 3;
    localparam int IN_W  = 14;
    localparam int OUT_W = 28;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    input_valid = 1'b0;
    logic                    input_ready;
    logic signed [IN_W-1:0]  input_data = '0;
    logic                    input_new_matrix = 1'b0;
    logic                    output_valid;
    logic                    output_ready = 1'b0;
    logic signed [OUT_W-1:0] output_data;
    logic                    output_last;

    always #5 clk = ~clk;

    matvec_param_stream #(.K(K), .IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .input_valid      (input_valid),
        .input_ready      (input_ready),
        .input_data       (input_data),
        .input_new_matrix (input_new_matrix),
        .output_valid     (output_valid),
        .output_ready     (output_ready),
        .output_data      (output_data),
        .output_last      (output_last)
    );

    typedef struct {
        logic signed [OUT_W-1:0] data;
        logic                    last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_last = 0;
    int   n_jobs = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: hold off
    bit   gap_en = 1'b0;
    bit   m_loaded = 1'b0;
    int   m_mat [K*K];
    int   m_vec [K];
    int   t_mat [K*K];
    int   t_vec [K];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference row result using 64-bit arithmetic.
    function automatic logic signed [OUT_W-1:0] model_row(input int r);
        longint p;
`ifdef MATVEC_SAT_EN
        longint acc  = 0;
        bit     sat  = 1'b0;
        longint maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint minv = -(longint'(1) <<< (OUT_W - 1));
        for (int c = 0; c < K; c++) begin
            p = longint'(m_mat[r*K+c]) * longint'(m_vec[c]);
            if (!sat) begin
                acc = acc + p;
                if (acc > maxv) begin
                    acc = maxv;
                    sat = 1'b1;
                end else if (acc < minv) begin
                    acc = minv;
                    sat = 1'b1;
                end
            end
        end
        return OUT_W'(acc);
`else
        logic signed [OUT_W-1:0] accw = '0;
        for (int c = 0; c < K; c++) begin
            p = longint'(m_mat[r*K+c]) * longint'(m_vec[c]);
            accw = accw + OUT_W'(p);
        end
        return accw;
`endif
    endfunction

    // Output monitor: drives output_ready and compares accepted results against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        case (ready_mode)
            0:       output_ready = 1'b1;
            1:       output_ready = ($urandom_range(1) == 1);
            default: output_ready = 1'b0;
        endcase
        if (reset_n && output_valid && output_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'(output_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("y", output_data, e.data);
                check_eq("last", 64'(output_last), 64'(e.last));
            end
            if (output_last) n_last++;
        end
    end

    task automatic send_word(input int d, input bit nm);
        int guard = 0;
        if (gap_en && $urandom_range(3) == 0) begin
            repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        @(negedge clk);
        input_valid      = 1'b1;
        input_data       = IN_W'(d);
        input_new_matrix = nm;
        while (!input_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("FAIL send_word: input_ready never rose");
                $fatal(1, "input stall");
            end
        end
        @(posedge clk);
        #1;
        input_valid      = 1'b0;
        input_data       = IN_W'($urandom);
        input_new_matrix = 1'($urandom_range(1));
    endtask

    // Sends one job from t_mat/t_vec and pushes its expected results.
    task automatic send_job(input bit nm);
        bit need_m = nm || !m_loaded;
        if (need_m) begin
            m_mat    = t_mat;
            m_loaded = 1'b1;
            for (int i = 0; i < K * K; i++) begin
                send_word(t_mat[i], (i == 0) ? nm : 1'($urandom_range(1)));
            end
        end
        m_vec = t_vec;
        for (int r = 0; r < K; r++) begin
            exp_t e;
            e.data = model_row(r);
            e.last = (r == K - 1);
            sb.push_back(e);
        end
        for (int i = 0; i < K; i++) begin
            send_word(t_vec[i], (i == 0 && !need_m) ? nm : 1'($urandom_range(1)));
        end
        n_jobs++;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic int rand_word();
        case ($urandom_range(7))
            0:       return -8192;
            1:       return 8191;
            default: return int'($urandom_range(16383)) - 8192;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        #12;
        check_eq("rst_in_ready", 64'(input_ready), 64'd0);
        check_eq("rst_out_valid", 64'(output_valid), 64'd0);
        check_eq("rst_out_data", output_data, 64'd0);
        check_eq("rst_out_last", 64'(output_last), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("ready_before_clk", 64'(input_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq("ready_after_clk", 64'(input_ready), 64'd1);

        // 1: identity, plus latency check.
        t_mat = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        t_vec = '{5, -7, 8191};
        send_job(1'b1);
        repeat (K) @(negedge clk);
        check_eq("latency_early", 64'(output_valid), 64'd0);
        @(negedge clk);
        check_eq("latency_on", 64'(output_valid), 64'd1);
        wait_drain();

        // 2: full matrix then reuse.
        t_mat = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        t_vec = '{1, 1, 1};
        send_job(1'b1);
        t_vec = '{-1, 0, 2};
        send_job(1'b0);
        wait_drain();

        // 3: all words at the negative extreme.
        t_mat = '{default: -8192};
        t_vec = '{default: -8192};
        send_job(1'b1);
        wait_drain();

        // 4: backpressure hold on y[0].
        ready_mode = 2;
        t_mat = '{3, -2, 1, 0, 7, -5, 100, 200, -300};
        t_vec = '{11, -13, 17};
        send_job(1'b1);
        begin
            int guard = 0;
            while (!output_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        input_valid = 1'b1;
        input_data  = IN_W'(1234);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(output_valid), 64'd1);
            check_eq("hold_data", output_data, sb[0].data);
            check_eq("hold_in_ready", 64'(input_ready), 64'd0);
        end
        input_valid = 1'b0;
        ready_mode  = 0;
        wait_drain();

        // 5: reset mid matrix load; next job flagged 0 must still load a matrix.
        for (int i = 0; i < 4; i++) send_word(50 + i, (i == 0) ? 1'b1 : 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_in_ready", 64'(input_ready), 64'd0);
        check_eq("arst_out_valid", 64'(output_valid), 64'd0);
        check_eq("arst_out_data", output_data, 64'd0);
        check_eq("arst_out_last", 64'(output_last), 64'd0);
        m_loaded = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        t_mat = '{-4, 9, 2, 8191, -8192, 1, 6, 6, -6};
        t_vec = '{100, -3, 42};
        send_job(1'b0);
        wait_drain();

        // 6: random traffic with ~25% matrix reuse.
        ready_mode = 1;
        gap_en     = 1'b1;
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < K * K; i++) t_mat[i] = rand_word();
            for (int i = 0; i < K; i++) t_vec[i] = rand_word();
            send_job(($urandom_range(3) == 0) ? 1'b0 : 1'b1);
        end
        wait_drain();
        check_eq("last_count", 64'(n_last), 64'(n_jobs));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
